// File: rtl/s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel deserializer.
// Holds the FSM state enum, counter sizing and saturating increment.
package s2p_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int frame);
        return (frame > 2) ? $clog2(frame) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] lim;
        lim = 32'hFFFF_FFFF >> (32 - w);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/s2p_fifo.sv
// Show-ahead FIFO with a registered head word.
// Push and pop in one cycle are both honoured at any fill level.
module s2p_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic [W-1:0]  r_head;
    logic [W-1:0]  w_head_nxt;
    logic [AW-1:0] w_rd_inc;
    logic          w_pop;
    logic          w_push;

    assign o_empty  = (r_cnt == '0);
    assign o_full   = (r_cnt == (AW+1)'(DEPTH));
    assign w_pop    = i_pop && !o_empty;
    assign w_push   = i_push && (!o_full || w_pop);
    assign w_rd_inc = r_rd + 1'b1;
    assign o_data   = r_head;

    // Head register tracks mem[r_rd], refilled from the next slot or the input
    always_comb begin
        w_head_nxt = r_head;
        if (w_pop) begin
            if (r_cnt > (AW+1)'(1))
                w_head_nxt = r_mem[w_rd_inc];
            else if (w_push)
                w_head_nxt = i_data;
        end else if (o_empty && w_push) begin
            w_head_nxt = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd   <= '0;
            r_wr   <= '0;
            r_cnt  <= '0;
            r_head <= '0;
        end else begin
            r_head <= w_head_nxt;
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= w_rd_inc;
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/serial2parallel.sv
// MSB-first deserializer with alignment tracking and an output FIFO.
// Define S2P_PARITY_EN for an extra even-parity bit per frame.
module serial2parallel
    import s2p_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sin,
    input  logic                 sin_sof,
    output logic [DATA_W-1:0]    dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 locked,
    output logic                 overflow,
    output logic [ERR_CNT_W-1:0] realign_cnt
`ifdef S2P_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

`ifdef S2P_PARITY_EN
    localparam int FRAME = DATA_W + 1;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int FRAME = DATA_W;
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int CNT_W = cnt_w(FRAME);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DATA_W-1:0]     r_sh;
    logic [DATA_W-1:0]     r_word;
    logic [DATA_W-1:0]     w_word;
    logic                  r_push;
    logic                  w_push_nxt;
    logic                  r_ovf;
    logic [ERR_CNT_W-1:0]  r_realign;
    logic                  w_shift;
    logic                  w_done;
    logic                  w_err;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        unique case (r_state)
            HUNT: begin
                if (sin_sof) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = CNT_W'(1);
                    w_shift     = 1'b1;
                end
            end
            SHIFT: begin
                // A marker anywhere but the boundary means we slipped
                if (sin_sof) begin
                    w_cnt_nxt = CNT_W'(1);
                    w_shift   = 1'b1;
                    w_err     = (r_cnt != '0);
                end else if (r_cnt == '0) begin
                    w_state_nxt = HUNT;
                    w_err       = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = '0;
                    w_shift   = !PAR_EN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    w_shift   = 1'b1;
                end
            end
        endcase
    end

`ifdef S2P_PARITY_EN
    logic r_perr;
    logic w_par_ok;

    assign w_word     = r_sh;
    assign w_par_ok   = ~^{r_sh, sin};
    assign w_push_nxt = w_done && w_par_ok;
    assign parity_err = r_perr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perr <= 1'b0;
        else
            r_perr <= w_done && !w_par_ok;
    end
`else
    assign w_word     = {r_sh[DATA_W-2:0], sin};
    assign w_push_nxt = w_done;
`endif

    assign w_pop = dout_valid && dout_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_word    <= '0;
            r_push    <= 1'b0;
            r_ovf     <= 1'b0;
            r_realign <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_push  <= w_push_nxt;
            r_ovf   <= r_push && w_full && !w_pop;
            if (w_shift)
                r_sh <= {r_sh[DATA_W-2:0], sin};
            if (w_done)
                r_word <= w_word;
            if (w_err)
                r_realign <= ERR_CNT_W'(sat_inc(32'(r_realign), ERR_CNT_W));
        end
    end

    s2p_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_word),
        .i_pop   (w_pop),
        .o_data  (dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dout_valid  = !w_empty;
    assign locked      = (r_state == SHIFT);
    assign overflow    = r_ovf;
    assign realign_cnt = r_realign;

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: vector table plus scoreboard.
module tb_serial2parallel;

`ifdef S2P_PARITY_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b0;
    logic       sin_sof = 1'b0;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b0;
    logic       locked;
    logic       overflow;
    logic [7:0] realign_cnt;
`ifdef S2P_PARITY_EN
    logic       parity_err;
`endif

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;
    int ovf_cnt = 0;
    logic [3:0] sb [$];
    int pop_t [$];

    typedef struct {
        logic [3:0] word;
        logic       exp_locked;
        logic [7:0] exp_realign;
    } vec_t;
    vec_t tbl [6];

    serial2parallel dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin         (sin),
        .sin_sof     (sin_sof),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .locked      (locked),
        .overflow    (overflow),
        .realign_cnt (realign_cnt)
`ifdef S2P_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n)
            ovf_cnt = 0;
        else if (overflow)
            ovf_cnt++;
        if (rst_n && dout_valid && dout_ready) begin
            n_vec++;
            pop_t.push_back(cyc);
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL pop_unexpected: got %h, expected no word", dout);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                if (dout !== e) begin
                    n_miss++;
                    $display("FAIL pop_data: got %h, expected %h", dout, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bit_cycle(input logic s, input logic b);
        sin_sof = s;
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            bit_cycle(1'b0, i[0]);
    endtask

    task automatic send_word(input logic [3:0] w, input logic flip);
        for (int i = 0; i < 4; i++)
            bit_cycle(i == 0, w[3-i]);
`ifdef S2P_PARITY_EN
        bit_cycle(1'b0, (^w) ^ flip);
`else
        if (flip) bit_cycle(1'b0, 1'b0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sin = 1'b0;
        sin_sof = 1'b0;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pop_t.delete();
    endtask

    initial begin
        tbl[0] = '{4'h3, 1'b1, 8'd0};
        tbl[1] = '{4'hC, 1'b1, 8'd0};
        tbl[2] = '{4'h5, 1'b1, 8'd0};
        tbl[3] = '{4'hA, 1'b1, 8'd0};
        tbl[4] = '{4'hF, 1'b1, 8'd0};
        tbl[5] = '{4'h0, 1'b1, 8'd0};

        do_reset();
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(dout_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_realign", 32'(realign_cnt), 0);

        // Alignment and latency, then a missing marker at the boundary
        send_word(4'hB, 1'b0);
        chk("align_locked", 32'(locked), 1);
        chk("align_realign", 32'(realign_cnt), 0);
        chk("align_valid_early", 32'(dout_valid), 0);
        @(posedge clk);
        #1;
        chk("align_valid", 32'(dout_valid), 1);
        chk("align_dout", 32'(dout), 32'hB);
        chk("nosof_locked", 32'(locked), 0);
        chk("nosof_realign", 32'(realign_cnt), 1);
        sb.push_back(4'hB);
        dout_ready = 1'b1;
        idle(6);
        chk("nosof_no_push", 32'(dout_valid), 0);
        chk("nosof_sb_empty", 32'(sb.size()), 0);

        // Marker arriving at cnt=2
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1);
        sb.push_back(4'h6);
        send_word(4'h6, 1'b0);
        chk("slip_realign", 32'(realign_cnt), 2);
        chk("slip_locked", 32'(locked), 1);
        idle(6);
        chk("slip_sb_empty", 32'(sb.size()), 0);
        chk("slip_valid", 32'(dout_valid), 0);

        // Back-to-back stream from the table
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(tbl[i].word);
            send_word(tbl[i].word, 1'b0);
            chk($sformatf("b2b_locked_%0d", i), 32'(locked),
                32'(tbl[i].exp_locked));
            chk($sformatf("b2b_realign_%0d", i), 32'(realign_cnt),
                32'(tbl[i].exp_realign));
        end
        idle(6);
        chk("b2b_overflow", 32'(ovf_cnt), 0);
        chk("b2b_sb_empty", 32'(sb.size()), 0);
        chk("b2b_pops", 32'(pop_t.size()), 6);
        for (int i = 1; i < pop_t.size(); i++)
            chk($sformatf("b2b_gap_%0d", i), 32'(pop_t[i] - pop_t[i-1]),
                32'(FRAME));

        // Backpressure with a full FIFO
        do_reset();
        sb.push_back(4'h3);
        sb.push_back(4'hC);
        send_word(4'h3, 1'b0);
        send_word(4'hC, 1'b0);
        send_word(4'h5, 1'b0);
        idle(3);
        chk("bp_overflow_cycles", 32'(ovf_cnt), 1);
        chk("bp_hold_valid", 32'(dout_valid), 1);
        chk("bp_hold_dout", 32'(dout), 32'h3);
        dout_ready = 1'b1;
        idle(4);
        chk("bp_sb_empty", 32'(sb.size()), 0);
        chk("bp_drained", 32'(dout_valid), 0);

        // Reset mid-word with one word buffered
        do_reset();
        send_word(4'h9, 1'b0);
        bit_cycle(1'b1, 1'b1);
        chk("mid_buffered", 32'(dout_valid), 1);
        bit_cycle(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(dout_valid), 0);
        chk("mid_locked", 32'(locked), 0);
        chk("mid_realign", 32'(realign_cnt), 0);
        chk("mid_dout", 32'(dout), 0);
        do_reset();
        idle(3);
        chk("mid_empty", 32'(dout_valid), 0);

        // Saturation: a marker every cycle slips on all but the first
        do_reset();
        for (int i = 0; i < 300; i++)
            bit_cycle(1'b1, 1'b0);
        chk("sat_realign", 32'(realign_cnt), (299 > 255) ? 255 : 299);
        chk("sat_locked", 32'(locked), 1);

`ifdef S2P_PARITY_EN
        do_reset();
        sb.push_back(4'hB);
        send_word(4'hB, 1'b0);
        chk("par_ok_err", 32'(parity_err), 0);
        @(posedge clk);
        #1;
        chk("par_ok_valid", 32'(dout_valid), 1);
        dout_ready = 1'b1;
        idle(3);
        chk("par_ok_sb", 32'(sb.size()), 0);

        do_reset();
        send_word(4'hB, 1'b1);
        chk("par_bad_err", 32'(parity_err), 1);
        chk("par_bad_locked", 32'(locked), 1);
        @(posedge clk);
        #1;
        chk("par_bad_pulse", 32'(parity_err), 0);
        chk("par_bad_valid", 32'(dout_valid), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Deserializer directly downstream of the 4-bit parallel-to-serial stage. Consumes one serial bit per clk plus a start-of-word marker, and reassembles MSB-first words.
- Buffers completed words in a small FIFO and presents them on a valid/ready parallel interface.
- Detects loss of word alignment and output overflow.

Parameters:
- DATA_W, 4: bits per word; also the serial frame length in cycles.
- FIFO_DEPTH, 2: output buffer entries; power of two, >= 2.
- ERR_CNT_W, 8: width of the saturating realignment counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- sin  input  1  serial data bit, sampled every cycle.
- sin_sof  input  1  start-of-word marker; high in the cycle carrying the word MSB.
- dout  output  DATA_W  assembled word at FIFO head.
- dout_valid  output  1  dout holds a valid word.
- dout_ready  input  1  consumer accepts dout when high together with dout_valid.
- locked  output  1  word alignment established.
- overflow  output  1  one-cycle pulse: completed word dropped because FIFO full.
- realign_cnt  output  ERR_CNT_W  saturating count of alignment errors.

Behaviour:
- Reset (async assert, sync release): state=HUNT, bit counter=0, shift register=0, FIFO empty. dout=0, dout_valid=0, locked=0, overflow=0, realign_cnt=0. Reset mid-word discards the partial word and all buffered words.
- Bit order is MSB first. The bit in the sin_sof cycle is dout[DATA_W-1]. The bit DATA_W-1 cycles later is dout[0].
- FSM states:
  - HUNT: ignore sin until sin_sof=1. On sof: capture sin as MSB, cnt=1, go to SHIFT, locked=1 from the next cycle.
  - SHIFT: each cycle shift sin in and increment cnt.
    - When cnt==DATA_W-1, the word is complete: push it to the FIFO and set cnt=0.
    - At cnt==0 (word boundary), sin_sof must be 1; it then starts the next word back-to-back.
    - If sin_sof=0 at cnt==0: go to HUNT, locked=0, realign_cnt+1.
    - If sin_sof=1 at cnt!=0: discard the partial word, realign_cnt+1, restart with this bit as MSB (cnt=1), stay in SHIFT.
- Continuous back-to-back words are sustained at full rate: one word every DATA_W cycles, no bubbles.
- Latency: dout_valid rises on the clock edge after the edge that samples the LSB, i.e. 1 cycle after LSB.
- FIFO behaviour:
  - Show-ahead (first-word fall-through); dout is registered.
  - Pop when dout_valid && dout_ready.
  - Push and pop in the same cycle are both honoured at any fill level, including full.
  - A push while full with no pop drops the new word and pulses overflow for 1 cycle. Alignment is unaffected.
- realign_cnt saturates at all-ones and never wraps.
- dout holds its value while dout_valid && !dout_ready.

Optional Feature:
- Macro: S2P_PARITY_EN.
- When defined:
  - The frame is DATA_W+1 bits: the data bits, then one even-parity bit. cnt runs 0..DATA_W.
  - On parity mismatch the word is not pushed, and output port parity_err (1 bit) pulses for 1 cycle in the push cycle.
  - Alignment is kept on parity error.
  - parity_err resets to 0.
- When undefined: the frame is DATA_W bits, no parity_err port, no parity logic.

Decomposition:
- Package s2p_pkg holds:
  - the state enum (HUNT, SHIFT);
  - the CNT_W localparam function (clog2 of frame length);
  - a saturating-increment helper function.
- Sub-module s2p_fifo: synchronous show-ahead FIFO, parameterised by width and depth, with push/pop/full/empty.
- Top level holds the FSM, shift register and counters.

Test Plan:
- Alignment: reset, then sof with serial bits 1,0,1,1 -> dout=4'hB with dout_valid=1 one cycle after the LSB; locked=1; realign_cnt=0.
- Back-to-back: stream words 4'h3, 4'hC, 4'h5 with dout_ready=1 -> three consecutive words, 4 cycles apart, in order, no overflow.
- Backpressure: dout_ready=0 while sending 3 words, FIFO_DEPTH=2 -> first two buffered; third dropped with overflow pulse of exactly 1 cycle. After dout_ready=1, the bench pops 4'h3 then 4'hC.
- Misalignment:
  - sof missing at a word boundary -> locked=0, realign_cnt=1, no word pushed until the next sof.
  - sof at cnt=2 -> partial word discarded, realign_cnt=2, the new word assembles correctly.
- Reset mid-word with 1 word buffered -> dout_valid=0, FIFO empty, HUNT state, realign_cnt=0 immediately on rst_n low.
- With S2P_PARITY_EN:
  - word 4'hB with parity bit 1 -> pushed.
  - word 4'hB with parity bit 0 -> parity_err pulse, no push, locked stays 1.
